// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with programmable limit, wrap/saturate boundaries,
// synchronous load, terminal-count pulse and sticky overflow/underflow flags.
module param_up_down_counter #(
    parameter int unsigned       WIDTH    = 8,
    parameter int unsigned       STEP_W   = 4,
    parameter int unsigned       SATURATE = 0,
    parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              d,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_zero,
    output logic              tc,
    output logic              ovf,
    output logic              unf
);

    // Common width wide enough to compare step against limit without truncation.
    localparam int unsigned CW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

    function automatic logic [WIDTH:0] eff_step(input logic [STEP_W-1:0] st,
                                                input logic [WIDTH-1:0]  lim);
        logic [CW-1:0] st_x;
        logic [CW-1:0] lim_x;
        st_x  = CW'(st);
        lim_x = CW'(lim);
        return (st_x < lim_x) ? (WIDTH+1)'(st_x) : {1'b0, lim};
    endfunction

    function automatic logic [WIDTH-1:0] clamp_to_limit(input logic [WIDTH-1:0] val,
                                                        input logic [WIDTH-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

    logic [WIDTH:0]   cnt_x, lim_x, lim1_x, s_x, sum_x;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt, ovf_set, unf_set;

    assign cnt_x  = {1'b0, count};
    assign lim_x  = {1'b0, limit};
    assign lim1_x = lim_x + 1'b1;
    assign s_x    = eff_step(step, limit);
    assign sum_x  = cnt_x + s_x;

    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (load) begin
            count_nxt = clamp_to_limit(load_val, limit);
        end else if (en) begin
            // A count stranded above a lowered limit is pulled back without a crossing.
            if (count > limit) begin
                count_nxt = limit;
            end else if (d) begin
                if (sum_x > lim_x) begin
                    tc_nxt    = 1'b1;
                    ovf_set   = 1'b1;
                    count_nxt = (SATURATE != 0) ? limit : WIDTH'(sum_x - lim1_x);
                end else begin
                    count_nxt = WIDTH'(sum_x);
                end
            end else begin
                if (s_x > cnt_x) begin
                    tc_nxt    = 1'b1;
                    unf_set   = 1'b1;
                    count_nxt = (SATURATE != 0) ? '0 : WIDTH'(cnt_x + lim1_x - s_x);
                end else begin
                    count_nxt = WIDTH'(cnt_x - s_x);
                end
            end
        end
    end

    // Register stage: a flag set in the same cycle as clr_flags wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_set | (ovf & ~clr_flags);
            unf   <= unf_set | (unf & ~clr_flags);
        end
    end

    assign at_max  = (count == limit);
    assign at_zero = (count == '0);

endmodule
